// File: rtl/mux_2_1_pkg.sv
// Shared constants for the two-input word multiplexer.
// Holds the legal WIDTH range and its elaboration-time check.
package mux_2_1_pkg;

    localparam int MUX_WIDTH_MIN = 1;
    localparam int MUX_WIDTH_MAX = 1024;
    localparam int MUX_WIDTH_DEF = 32;

    function automatic bit width_ok(input int w);
        return (w >= MUX_WIDTH_MIN) && (w <= MUX_WIDTH_MAX);
    endfunction

endpackage

// File: rtl/mux_2_1_if.sv
// Data/select bundle for mux_2_1.
// The master drives the words and select; the slave returns the outputs.
interface mux_2_1_if #(
    parameter int WIDTH = 32
);

    logic [WIDTH-1:0] f_in;
    logic [WIDTH-1:0] s_in;
    logic             select;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic             sel_q;

    modport master (
        output f_in,
        output s_in,
        output select,
        input  out,
        input  out_q,
        input  sel_q
    );

    modport slave (
        input  f_in,
        input  s_in,
        input  select,
        output out,
        output out_q,
        output sel_q
    );

endinterface

// File: rtl/mux_2_1.sv
// Two-input word multiplexer with a combinational output and a
// registered copy; clk/rst (active-low, async) touch only the copy.
module mux_2_1
    import mux_2_1_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH_DEF
) (
    input  logic      clk,
    input  logic      rst,
    mux_2_1_if.slave  bus
);

    if (!width_ok(WIDTH)) begin : g_width_chk
        $error("mux_2_1: WIDTH %0d outside 1..1024", WIDTH);
    end

    logic [WIDTH-1:0] out_c;

    // An unknown select only yields data when both words agree;
    // otherwise the X propagates rather than quietly choosing f_in.
    always_comb begin
        out_c = bus.f_in;
        if (bus.select) begin
            out_c = bus.s_in;
        end else if (!bus.select) begin
            out_c = bus.f_in;
        end else begin
            out_c = (bus.f_in == bus.s_in) ? bus.f_in : 'x;
        end
    end

    assign bus.out = out_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.out_q <= '0;
            bus.sel_q <= 1'b0;
        end else begin
            bus.out_q <= out_c;
            bus.sel_q <= bus.select;
        end
    end

endmodule

// File: tb/tb_mux_2_1.sv
// Self-checking bench for mux_2_1 at WIDTH 32, 1 and 64.
// Table vectors, directed reset sequences and a random reference model.
module tb_mux_2_1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mux_2_1_if #(.WIDTH(32)) ifc32 ();
    mux_2_1_if #(.WIDTH(1))  ifc1  ();
    mux_2_1_if #(.WIDTH(64)) ifc64 ();

    mux_2_1 #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(ifc32.slave));
    mux_2_1 #(.WIDTH(1))  dut1  (.clk(clk), .rst(rst), .bus(ifc1.slave));
    mux_2_1 #(.WIDTH(64)) dut64 (.clk(clk), .rst(rst), .bus(ifc64.slave));

    typedef struct {
        logic [31:0] f;
        logic [31:0] s;
        logic        sel;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic drive32(input logic [31:0] f,
                           input logic [31:0] s,
                           input logic sel);
        ifc32.f_in   = f;
        ifc32.s_in   = s;
        ifc32.select = sel;
    endtask

    logic [31:0] exp_q [$];
    logic        exp_s [$];

    initial begin
        logic        probe;
        bit          four_state;
        logic [63:0] all_x;
        logic [31:0] rf, rs, ro;
        logic        rsel;
        logic [63:0] w64f, w64s, w64o, w64prev;
        logic        w1f, w1s, w1o, w1prev;

        probe      = 1'bx;
        four_state = (probe === 1'bx);
        all_x      = {32'h0, {32{1'bx}}};

        vecs[0] = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF};
        vecs[1] = '{32'hDEAD_BEEF, 32'h1234_5678, 1'b1, 32'h1234_5678};
        vecs[2] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0000_0000};
        vecs[3] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF};
        vecs[4] = '{32'hAAAA_5555, 32'h5555_AAAA, 1'b1, 32'h5555_AAAA};
        vecs[5] = '{32'hAAAA_5555, 32'h5555_AAAA, 1'b0, 32'hAAAA_5555};
        vecs[6] = '{32'h8000_0001, 32'h8000_0001, 1'b1, 32'h8000_0001};
        vecs[7] = '{32'h0000_000A, 32'h0000_000B, 1'b0, 32'h0000_000A};

        drive32(32'h0, 32'h0, 1'b0);
        ifc1.f_in  = 1'b0;
        ifc1.s_in  = 1'b0;
        ifc1.select = 1'b0;
        ifc64.f_in = '0;
        ifc64.s_in = '0;
        ifc64.select = 1'b0;

        #1 rst = 1'b0;
        #1;
        chk("rst_out_q", {32'h0, ifc32.out_q}, 64'h0);
        chk("rst_sel_q", {63'h0, ifc32.sel_q}, 64'h0);
        chk("rst_out_q64", ifc64.out_q, 64'h0);

        // Table vectors while held in reset: out live, copy stays 0.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive32(vecs[i].f, vecs[i].s, vecs[i].sel);
            #1;
            chk($sformatf("tbl_out[%0d]", i),
                {32'h0, ifc32.out}, {32'h0, vecs[i].exp});
            @(posedge clk);
            #1;
            chk($sformatf("tbl_rst_q[%0d]", i),
                {32'h0, ifc32.out_q}, 64'h0);
            chk($sformatf("tbl_rst_s[%0d]", i),
                {63'h0, ifc32.sel_q}, 64'h0);
        end

        // Release away from the edge, then select 1,0,1 with A/B.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            logic sv;
            sv = (i != 1);
            if (i != 0) @(negedge clk);
            drive32(32'hA, 32'hB, sv);
            @(posedge clk);
            #1;
            chk($sformatf("ab_out_q[%0d]", i), {32'h0, ifc32.out_q},
                {32'h0, sv ? 32'hB : 32'hA});
            chk($sformatf("ab_sel_q[%0d]", i),
                {63'h0, ifc32.sel_q}, {63'h0, sv});
        end

        // Async clear mid-cycle, before the next rising edge.
        #2 rst = 1'b0;
        #1;
        chk("async_out_q", {32'h0, ifc32.out_q}, 64'h0);
        chk("async_sel_q", {63'h0, ifc32.sel_q}, 64'h0);
        ifc32.select = 1'b0;
        #1;
        chk("async_out_live", {32'h0, ifc32.out}, 64'hA);
        @(negedge clk);
        rst = 1'b1;

        ifc32.select = 1'bx;
        ifc32.f_in   = 32'h55;
        ifc32.s_in   = 32'h55;
        #1;
        chk("x_sel_equal", {32'h0, ifc32.out}, 64'h55);
        if (four_state) begin
            ifc32.f_in = 32'h0;
            ifc32.s_in = 32'hFFFF_FFFF;
            #1;
            chk("x_sel_diff", {32'h0, ifc32.out}, all_x);
        end

        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            rf   = $urandom;
            rs   = $urandom;
            rsel = 1'($urandom_range(0, 1));
            ro   = rsel ? rs : rf;
            drive32(rf, rs, rsel);
            exp_q.push_back(ro);
            exp_s.push_back(rsel);
            #1;
            chk("rnd_out", {32'h0, ifc32.out}, {32'h0, ro});
            @(posedge clk);
            #1;
            chk("rnd_out_q", {32'h0, ifc32.out_q},
                {32'h0, exp_q.pop_front()});
            chk("rnd_sel_q", {63'h0, ifc32.sel_q},
                {63'h0, exp_s.pop_front()});
        end

        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            rsel = 1'(i % 2);
            w64f = 64'h1 << i;
            w64s = 64'h1 << (63 - i);
            w1f  = 1'(i % 2);
            w1s  = ~w1f;
            ifc64.f_in = w64f;
            ifc64.s_in = w64s;
            ifc64.select = rsel;
            ifc1.f_in = w1f;
            ifc1.s_in = w1s;
            ifc1.select = rsel;
            w64o = rsel ? w64s : w64f;
            w1o  = rsel ? w1s : w1f;
            #1;
            chk($sformatf("walk64_out[%0d]", i), ifc64.out, w64o);
            chk($sformatf("walk1_out[%0d]", i),
                {63'h0, ifc1.out}, {63'h0, w1o});
            w64prev = w64o;
            w1prev  = w1o;
            @(posedge clk);
            #1;
            chk($sformatf("walk64_q[%0d]", i), ifc64.out_q, w64prev);
            chk($sformatf("walk1_q[%0d]", i),
                {63'h0, ifc1.out_q}, {63'h0, w1prev});
            chk($sformatf("walk1_sel_q[%0d]", i),
                {63'h0, ifc1.sel_q}, {63'h0, rsel});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
